adder_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline wrapper that shares the single 32-bit prefix adder between several requesters, such as the ALU, address generation and PC increment. It grants at most one request per cycle, registers the operands, evaluates them through the prefix adder and returns a tagged one-cycle result pulse to the winning requester. Throughput is one operation per cycle and latency is fixed.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/prefix_add32.sv | 33 +++
 rtl/adder_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder arbiter slice.
package adder_pkg;

    localparam int unsigned W_DEF    = 32;
    localparam int unsigned NREQ_MAX = 4;
    localparam int unsigned TAG_W    = 2;

    typedef struct packed {
        logic [W_DEF-1:0] a;
        logic [W_DEF-1:0] b;
        logic             cin;
        logic [TAG_W-1:0] tag;
        logic             v;
    } add_op_t;

    typedef struct packed {
        logic [W_DEF-1:0] sum;
        logic             cout;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic             v;
    } add_rsp_t;

endpackage

// File: rtl/prefix_add32.sv
// Combinational Kogge-Stone prefix adder: sum = a + b + cin.
module prefix_add32 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0] p0;
    logic [W-1:0] g;
    logic [W-1:0] p;

    // cin is folded into bit 0's generate, so g[i] becomes the carry out of bit i
    always_comb begin
        p0    = a ^ b;
        g     = a & b;
        g[0]  = g[0] | (p0[0] & cin);
        p     = p0;
        for (int unsigned d = 1; d < W; d = d << 1) begin
            g = g | (p & (g << d));
            p = p & ((p << d) | ~(ONES << d));
        end
    end

    assign sum  = p0 ^ {g[W-2:0], cin};
    assign cout = g[W-1];

endmodule

// File: rtl/adder_arbiter.sv
// Shares one prefix adder among NREQ requesters through a two-stage pipeline.
// Define ADDER_ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    input  logic              flush,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic              busy
);

    logic [W-1:0]     a_arr [NREQ];
    logic [W-1:0]     b_arr [NREQ];
    logic             hs;
    logic [TAG_W-1:0] gnt_idx;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic             sub_sel;
    add_op_t          op;
    add_rsp_t         rsp;
    logic [W-1:0]     sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]     = req_a[i*W +: W];
        assign b_arr[i]     = req_b[i*W +: W];
        assign req_ready[i] = hs && (gnt_idx == TAG_W'(i));
        assign rsp_valid[i] = rsp.v && (rsp.tag == TAG_W'(i));
    end

`ifdef ADDER_ARB_RR_EN
    localparam logic [TAG_W-1:0] LAST = TAG_W'(NREQ - 1);

    logic [TAG_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        int unsigned      idx;
        logic [TAG_W-1:0] sel;
        hs      = 1'b0;
        gnt_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_RR_EN
            idx = k + 32'(ptr);
            if (idx >= NREQ) idx = idx - NREQ;
`else
            idx = k;
`endif
            sel = TAG_W'(idx);
            if (!hs && req_valid[sel]) begin
                hs      = 1'b1;
                gnt_idx = sel;
                a_sel   = a_arr[sel];
                b_sel   = b_arr[sel];
                sub_sel = req_sub[sel];
            end
        end
        if (flush) hs = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= '0;
        end else if (hs) begin
            op.a   <= a_sel;
            op.b   <= sub_sel ? ~b_sel : b_sel;
            op.cin <= sub_sel;
            op.tag <= gnt_idx;
            op.v   <= 1'b1;
        end else begin
            op.v   <= 1'b0;
        end
    end

    prefix_add32 #(.W(W)) u_add (
        .a    (op.a),
        .b    (op.b),
        .cin  (op.cin),
        .sum  (sum_nxt),
        .cout (cout_nxt)
    );

    // b is already inverted for subtraction, so one rule covers add and sub
    assign ovf_nxt = (op.a[W-1] == op.b[W-1]) && (sum_nxt[W-1] != op.a[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp <= '0;
        end else begin
            rsp.v <= op.v && !flush;
            if (op.v && !flush) begin
                rsp.sum  <= sum_nxt;
                rsp.cout <= cout_nxt;
                rsp.ovf  <= ovf_nxt;
                rsp.tag  <= op.tag;
            end
        end
    end

    assign rsp_sum  = rsp.sum;
    assign rsp_cout = rsp.cout;
    assign rsp_ovf  = rsp.ovf;
    assign busy     = op.v | rsp.v;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter against a cycle-indexed response model.
module tb_adder_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 32;

    typedef struct {
        int          tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;
    logic              busy;

    logic [W-1:0] a_in [NREQ];
    logic [W-1:0] b_in [NREQ];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_t        sched [int];
    int          mptr;
    int          eg;
    int          idx;
    exp_t        cur;
    logic [31:0] last_sum;
    logic        last_cout;
    logic        last_ovf;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] g;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_a[gi*W +: W] = a_in[gi];
        assign req_b[gi*W +: W] = b_in[gi];
    end

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic exp_t model_op(input int t, input logic [31:0] a, input logic [31:0] b,
                                      input logic s);
        exp_t        e;
        logic [32:0] f;
        e.tag = t;
        if (s) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            e.ovf  = (a[31] != b[31]) && (e.sum[31] != a[31]);
        end else begin
            f      = {1'b0, a} + {1'b0, b};
            e.sum  = f[31:0];
            e.cout = f[32];
            e.ovf  = (a[31] == b[31]) && (e.sum[31] != a[31]);
        end
        return e;
    endfunction

    // Model: a grant in cycle t schedules its response for cycle t+2
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            chk("rst_rsp_ovf", rsp_ovf, 0);
            sched.delete();
            mptr      = 0;
            last_sum  = '0;
            last_cout = 1'b0;
            last_ovf  = 1'b0;
        end else begin
            eg = -1;
            if (!flush) begin
                for (int k = 0; k < NREQ; k++) begin
`ifdef ADDER_ARB_RR_EN
                    idx = (mptr + k) % NREQ;
`else
                    idx = k;
`endif
                    if (eg < 0 && req_valid[idx]) eg = idx;
                end
            end
            exp_ready = '0;
            if (eg >= 0) exp_ready[eg] = 1'b1;
            chk("req_ready", req_ready, exp_ready);

            exp_rv = '0;
            if (sched.exists(cyc)) begin
                cur          = sched[cyc];
                exp_rv[cur.tag] = 1'b1;
                last_sum     = cur.sum;
                last_cout    = cur.cout;
                last_ovf     = cur.ovf;
            end
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_sum", rsp_sum, last_sum);
            chk("rsp_cout", rsp_cout, last_cout);
            chk("rsp_ovf", rsp_ovf, last_ovf);
            chk("busy", busy, sched.exists(cyc) || sched.exists(cyc + 1));

            if (flush && sched.exists(cyc + 1)) sched.delete(cyc + 1);
            if (sched.exists(cyc)) sched.delete(cyc);
            if (eg >= 0) begin
                sched[cyc + 2] = model_op(eg, a_in[eg], b_in[eg], req_sub[eg]);
                mptr = (eg + 1) % NREQ;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        a_in[i]      = a;
        b_in[i]      = b;
        req_sub[i]   = s;
        req_valid[i] = 1'b1;
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] es, input logic ec, input logic eo);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        set_req(i, a, b, s);
        #1 chk("lit_ready", req_ready, oh);
        tick();
        req_valid = '0;
        tick();
        chk("lit_rsp_valid", rsp_valid, oh);
        chk("lit_sum", rsp_sum, es);
        chk("lit_cout", rsp_cout, ec);
        chk("lit_ovf", rsp_ovf, eo);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [NREQ-1:0] oh;
        rst_n     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        single(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0);
        single(1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single(2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // all three requesting continuously
        set_req(0, 32'd100, 32'd1, 1'b0);
        set_req(1, 32'd200, 32'd2, 1'b1);
        set_req(2, 32'd300, 32'd3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            oh = '0;
`ifdef ADDER_ARB_RR_EN
            oh[k % 3] = 1'b1;
`else
            oh[0] = 1'b1;
`endif
            #1 chk("rr_grant", req_ready, oh);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // flush after two back-to-back handshakes
        set_req(0, 32'd11, 32'd22, 1'b0);
        tick();
        req_valid = '0;
        set_req(1, 32'd33, 32'd44, 1'b1);
        tick();
        req_valid = '0;
        set_req(2, 32'd55, 32'd66, 1'b0);
        flush = 1'b1;
        #1 chk("flush_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_rsp_valid", rsp_valid, 0);
        #1 chk("post_flush_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // reset with both stages full
        set_req(0, 32'd1, 32'd2, 1'b0);
        tick();
        req_valid = '0;
        set_req(1, 32'd3, 32'd4, 1'b0);
        tick();
        req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sum", rsp_sum, 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        set_req(2, 32'd9, 32'd4, 1'b1);
        #1 chk("post_rst_grant", req_ready, 3'b001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;
        repeat (3) tick();

        // randomized traffic honouring the hold-until-granted rule
        repeat (3000) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || g[i]) begin
                    if ($urandom_range(0, 3) != 0) set_req(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
                    else req_valid[i] = 1'b0;
                end
            end
            flush = ($urandom_range(0, 15) == 0);
        end
        flush     = 1'b0;
        req_valid = '0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
